aes_inv_round_ctrl: RTL and testbench

AES_INV_ROUND_CTRL -- requirements
Module: aes_inv_round_ctrl

---
 rtl/aes_inv_round_ctrl.sv | 106 ++++++++++
 tb/tb_aes_inv_round_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_round_ctrl.sv
// AES inverse-cipher round sequencer.
// Steps round-key indices Nr down to 0 for one block decryption.
module aes_inv_round_ctrl #(
  parameter int CNT_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [1:0]          i_key_len,
  input  logic                i_stall,
  input  logic                i_abort,
  output logic                o_busy,
  output logic                o_round_en,
  output logic [CNT_SIZE-1:0] o_round_key_idx,
  output logic                o_first,
  output logic                o_last,
  output logic                o_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_SIZE-1:0] NR128 = CNT_SIZE'(10);
  localparam logic [CNT_SIZE-1:0] NR192 = CNT_SIZE'(12);
  localparam logic [CNT_SIZE-1:0] NR256 = CNT_SIZE'(14);
  localparam logic [CNT_SIZE-1:0] ONE   = CNT_SIZE'(1);

  state_t              state_q, state_d;
  logic [CNT_SIZE-1:0] cnt_q, cnt_d;
  logic [CNT_SIZE-1:0] nr_q, nr_d;
  logic [CNT_SIZE-1:0] nr_sel;
  logic                cnt_zero;

  always_comb begin
    unique case (i_key_len)
      2'b01:   nr_sel = NR192;
      2'b10:   nr_sel = NR256;
      default: nr_sel = NR128;
    endcase
  end

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nr_d    = nr_q;
    unique case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          state_d = INIT;
          nr_d    = nr_sel;
          cnt_d   = nr_sel;
        end
      end
      INIT: begin
        if (!i_stall) begin
          state_d = ROUND;
          cnt_d   = nr_q - ONE;
        end
      end
      ROUND: begin
        if (!i_stall) begin
          if (cnt_zero) state_d = DONE;
          else          cnt_d   = cnt_q - ONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort beats stall and the DONE hand-off.
    if (i_abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nr_q    <= NR128;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nr_q    <= nr_d;
    end
  end

  logic active;

  always_comb begin
    active          = (state_q == INIT) || (state_q == ROUND);
    o_busy          = (state_q != IDLE);
    o_round_en      = active && !i_stall;
    o_round_key_idx = active ? cnt_q : '0;
    o_first         = (state_q == INIT);
    o_last          = (state_q == ROUND) && cnt_zero;
    o_done          = (state_q == DONE);
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Scoreboard bench for aes_inv_round_ctrl.
// Reference model keeps the pending key-index list per block.
module tb_aes_inv_round_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [1:0]    i_key_len;
  logic          i_stall;
  logic          i_abort;
  logic          o_busy;
  logic          o_round_en;
  logic [CW-1:0] o_round_key_idx;
  logic          o_first;
  logic          o_last;
  logic          o_done;

  aes_inv_round_ctrl #(.CNT_SIZE(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .i_key_len       (i_key_len),
    .i_stall         (i_stall),
    .i_abort         (i_abort),
    .o_busy          (o_busy),
    .o_round_en      (o_round_en),
    .o_round_key_idx (o_round_key_idx),
    .o_first         (o_first),
    .o_last          (o_last),
    .o_done          (o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en;
    bit done;
    int idx;
    bit first;
    bit last;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  exp_busy = 0;

  // model state
  bit  m_busy = 0;
  int  m_nr = 10;
  int  m_steps[$];

  function automatic int nr_of(input bit [1:0] kl);
    if (kl == 2'b01) return 12;
    if (kl == 2'b10) return 14;
    return 10;
  endfunction

  task automatic drive(input bit st, input bit [1:0] kl,
                       input bit sl, input bit ab);
    ev_t e;
    i_start   = st;
    i_key_len = kl;
    i_stall   = sl;
    i_abort   = ab;
    exp_busy  = m_busy;
    if (m_busy) begin
      if (m_steps.size() != 0) begin
        if (!sl) begin
          e.en    = 1;
          e.done  = 0;
          e.idx   = m_steps[0];
          e.first = (m_steps.size() == m_nr + 1);
          e.last  = (m_steps.size() == 1);
          sb.push_back(e);
        end
      end else begin
        e.en = 0; e.done = 1; e.idx = 0;
        e.first = 0; e.last = 0;
        sb.push_back(e);
      end
    end
  endtask

  task automatic edge_update(input bit st, input bit [1:0] kl,
                             input bit sl, input bit ab);
    @(posedge clk);
    if (m_busy && ab) begin
      m_busy = 0;
      m_steps.delete();
    end else if (m_busy) begin
      if (m_steps.size() != 0) begin
        if (!sl) void'(m_steps.pop_front());
      end else begin
        m_busy = 0;
      end
    end else if (st && !ab) begin
      m_busy = 1;
      m_nr   = nr_of(kl);
      m_steps.delete();
      for (int k = m_nr; k >= 0; k--) m_steps.push_back(k);
    end
    #1;
  endtask

  task automatic cycle(input bit st, input bit [1:0] kl,
                       input bit sl, input bit ab);
    drive(st, kl, sl, ab);
    edge_update(st, kl, sl, ab);
  endtask

  task automatic bound_fail(input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL timeout %s: model still busy, required idle", what);
  endtask

  task automatic run_block(input bit [1:0] kl);
    int g = 0;
    cycle(1, kl, 0, 0);
    while (m_busy && g < 40) begin
      cycle(0, 2'($urandom_range(0, 3)), 0, 0);
      g++;
    end
    if (m_busy) bound_fail("run_block");
  endtask

  // monitor
  always @(negedge clk) begin
    ev_t e;
    n_cmp++;
    if (o_busy !== exp_busy) begin
      n_bad++;
      $display("FAIL busy t=%0t: got %b, required %b",
               $time, o_busy, exp_busy);
    end
    if (o_round_en || o_done) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL spurious t=%0t: en=%b done=%b idx=%0d, required none",
                 $time, o_round_en, o_done, o_round_key_idx);
      end else begin
        e = sb.pop_front();
        if (o_round_en !== e.en || o_done !== e.done ||
            int'(o_round_key_idx) != e.idx ||
            o_first !== e.first || o_last !== e.last) begin
          n_bad++;
          $display("FAIL event t=%0t: en=%b done=%b idx=%0d f=%b l=%b, required en=%b done=%b idx=%0d f=%b l=%b",
                   $time, o_round_en, o_done, o_round_key_idx,
                   o_first, o_last, e.en, e.done, e.idx,
                   e.first, e.last);
        end
      end
    end else if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      e = sb.pop_front();
      $display("FAIL missed t=%0t: no event, required en=%b done=%b idx=%0d",
               $time, e.en, e.done, e.idx);
    end
    if (!exp_busy) begin
      n_cmp++;
      if ({o_round_en, o_first, o_last, o_done} !== 4'b0 ||
          o_round_key_idx !== '0) begin
        n_bad++;
        $display("FAIL idle_out t=%0t: en=%b f=%b l=%b d=%b idx=%0d, required 0",
                 $time, o_round_en, o_first, o_last, o_done,
                 o_round_key_idx);
      end
    end
  end

  task automatic check_zero(input string what);
    n_cmp++;
    if ({o_busy, o_round_en, o_first, o_last, o_done} !== 5'b0 ||
        o_round_key_idx !== '0) begin
      n_bad++;
      $display("FAIL %s: busy=%b en=%b f=%b l=%b d=%b idx=%0d, required all 0",
               what, o_busy, o_round_en, o_first, o_last, o_done,
               o_round_key_idx);
    end
  endtask

  initial begin
    int g;
    int scnt;
    rst_n     = 1'b0;
    i_start   = 1'b0;
    i_key_len = 2'b00;
    i_stall   = 1'b0;
    i_abort   = 1'b0;
    #3;
    check_zero("reset_state");
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // abort while idle, and abort+start together: ignored
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 0);

    // AES-128, AES-256, reserved, back-to-back
    run_block(2'b00);
    run_block(2'b10);
    run_block(2'b11);
    cycle(0, 0, 0, 0);

    // AES-192 with a 3-cycle stall at idx 7
    cycle(1, 2'b01, 0, 0);
    scnt = 0;
    g = 0;
    while (m_busy && g < 60) begin
      if (m_steps.size() != 0 && m_steps[0] == 7 && scnt < 3) begin
        cycle(0, 2'b01, 1, 0);
        scnt++;
      end else begin
        cycle(0, 2'b01, 0, 0);
      end
      g++;
    end
    if (m_busy) bound_fail("stall192");

    // abort at idx 5 with stall high, then full block
    cycle(1, 2'b10, 0, 0);
    g = 0;
    while (m_busy && !(m_steps.size() != 0 && m_steps[0] == 5) && g < 40) begin
      cycle(0, 2'b10, 0, 0);
      g++;
    end
    cycle(0, 2'b10, 1, 1);
    cycle(0, 2'b10, 0, 0);
    cycle(0, 2'b10, 0, 0);
    run_block(2'b00);

    // start held high continuously
    for (int i = 0; i < 60; i++)
      cycle(1, 2'($urandom_range(0, 3)), 0, 0);
    g = 0;
    while (m_busy && g < 40) begin
      cycle(0, 0, 0, 0);
      g++;
    end
    if (m_busy) bound_fail("held_start");

    // async reset at idx 3
    cycle(1, 2'b00, 0, 0);
    g = 0;
    while (m_busy && !(m_steps.size() != 0 && m_steps[0] == 3) && g < 40) begin
      cycle(0, 0, 0, 0);
      g++;
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    m_busy = 0;
    m_steps.delete();
    exp_busy = 0;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    run_block(2'b01);

    // random traffic
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);

    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 0);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d pending events, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
